// File: rtl/ex_div_pkg.sv
// Shared constants and types for the EX-stage RV32M divider.
package ex_div_pkg;

  localparam int unsigned DIV_XLEN   = 32;
  localparam int unsigned DIV_ITER_W = 6;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    DivIdle  = 2'd0,
    DivStart = 2'd1,
    DivCalc  = 2'd2,
    DivEnd   = 2'd3
  } div_state_e;

endpackage

// File: rtl/ex_div_if.sv
// Handshake and data bundle between the EX stage / ctrl and the divider.
interface ex_div_if #(
  parameter int unsigned XLEN = ex_div_pkg::DIV_XLEN
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] dividend_i;
  logic [XLEN-1:0] divisor_i;
  logic [4:0]      reg_wr_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic            ready_o;
  logic [XLEN-1:0] result_o;
  logic [4:0]      reg_wr_addr_o;
  logic            reg_wr_en_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    input  busy_o, ready_o, result_o, reg_wr_addr_o, reg_wr_en_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_wr_addr_i, flush_i,
    output busy_o, ready_o, result_o, reg_wr_addr_o, reg_wr_en_o
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU; one quotient bit per cycle,
// writeback pulse registered on the edge that leaves the END state.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int unsigned XLEN   = DIV_XLEN,
  parameter int unsigned ITER_W = DIV_ITER_W
) (
  input logic     clk,
  input logic     rst_n,
  ex_div_if.slave bus
);

  div_state_e        state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        rd_out_q, rd_out_d;
  logic [XLEN-1:0]   dividend_q, dividend_d;
  logic [XLEN-1:0]   divisor_q, divisor_d;
  logic [XLEN-1:0]   quot_q, quot_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic              quot_neg_q, quot_neg_d;
  logic              rem_neg_q, rem_neg_d;
  logic              ready_q, ready_d;

  logic            is_signed, is_rem, dvd_neg, dvs_neg;
  logic [XLEN:0]   shifted, diff;

  // funct3 bit 0 clear selects the signed variants, bit 1 selects remainder
  assign is_signed = ~op_q[0];
  assign is_rem    = op_q[1];
  assign dvd_neg   = is_signed & dividend_q[XLEN-1];
  assign dvs_neg   = is_signed & divisor_q[XLEN-1];

  assign shifted = {rem_q, quot_q[XLEN-1]};
  assign diff    = shifted - {1'b0, divisor_q};

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rd_out_d   = rd_out_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    quot_neg_d = quot_neg_q;
    rem_neg_d  = rem_neg_q;
    ready_d    = 1'b0;

    case (state_q)
      DivIdle: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d       = bus.op_i;
          rd_d       = bus.reg_wr_addr_i;
          dividend_d = bus.dividend_i;
          divisor_d  = bus.divisor_i;
          state_d    = DivStart;
        end
      end
      DivStart: begin
        if (divisor_q == '0) begin
          state_d = DivEnd;
        end else begin
          quot_d     = dvd_neg ? -dividend_q : dividend_q;
          divisor_d  = dvs_neg ? -divisor_q : divisor_q;
          quot_neg_d = dvd_neg ^ dvs_neg;
          rem_neg_d  = dvd_neg;
          rem_d      = '0;
          cnt_d      = '0;
          state_d    = DivCalc;
        end
      end
      DivCalc: begin
        if (!diff[XLEN]) begin
          rem_d  = diff[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d  = shifted[XLEN-1:0];
          quot_d = {quot_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == ITER_W'(XLEN - 1)) state_d = DivEnd;
      end
      DivEnd: begin
        ready_d  = 1'b1;
        rd_out_d = rd_q;
        state_d  = DivIdle;
        // divisor_q only stays zero when START took the divide-by-zero exit
        if (divisor_q == '0) begin
          result_d = is_rem ? dividend_q : '1;
        end else if (is_rem) begin
          result_d = rem_neg_q ? -rem_q : rem_q;
        end else begin
          result_d = quot_neg_q ? -quot_q : quot_q;
        end
      end
      default: state_d = DivIdle;
    endcase

    if (bus.flush_i && (state_q != DivIdle)) begin
      state_d  = DivIdle;
      ready_d  = 1'b0;
      result_d = result_q;
      rd_out_d = rd_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DivIdle;
      op_q       <= '0;
      rd_q       <= '0;
      rd_out_q   <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      result_q   <= '0;
      cnt_q      <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rd_out_q   <= rd_out_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      quot_neg_q <= quot_neg_d;
      rem_neg_q  <= rem_neg_d;
      ready_q    <= ready_d;
    end
  end

  assign bus.busy_o        = bus.start_i | (state_q == DivStart) | (state_q == DivCalc);
  assign bus.ready_o       = ready_q;
  assign bus.reg_wr_en_o   = ready_q;
  assign bus.result_o      = result_q;
  assign bus.reg_wr_addr_o = rd_out_q;

endmodule
